kmul_dot_acc: RTL and testbench



---
 rtl/kmul_dot_acc.sv | 131 +++++++++++++
 tb/tb_kmul_dot_acc.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmul_dot_acc.sv
// Dot-product accumulator for the 32x32 Karatsuba multiplier output stream.
// Optional KMUL_ACC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module kmul_dot_acc #(
    parameter int PW    = 64,
    parameter int GW    = 16,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PW-1:0]        in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PW+GW-1:0]     out_acc,
    output logic [LEN_W-1:0]     out_count,
    output logic                 out_ovf
);

    localparam int AW = PW + GW;
    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]    acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;
    logic             accept;
    logic [AW:0]      sum;
    logic             carry;
    logic [AW-1:0]    acc_nxt;

    assign accept = in_valid & in_ready;
    assign sum    = {1'b0, acc} + {{(GW + 1){1'b0}}, in_prod};
    assign carry  = sum[AW];

`ifdef KMUL_ACC_SAT_EN
    // Once clamped, any further add either carries again or adds zero.
    assign acc_nxt = carry ? {AW{1'b1}} : sum[AW-1:0];
`else
    assign acc_nxt = sum[AW-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept && in_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        unique case (state)
            IDLE: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            ACC: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    // The first beat of a group restarts the datapath rather than adding to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc <= {{GW{1'b0}}, in_prod};
                cnt <= CNT_ONE;
                ovf <= 1'b0;
            end else begin
                acc <= acc_nxt;
                ovf <= ovf | carry;
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    assign out_acc   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_kmul_dot_acc.sv
// Randomised and directed bench for kmul_dot_acc, one wide instance and one
// narrow instance (GW=1, LEN_W=2) for overflow and count saturation.
module tb_kmul_dot_acc;

    localparam int PW  = 64;
    localparam int GW  = 16;
    localparam int LW  = 8;
    localparam int AW  = PW + GW;
    localparam int BGW = 1;
    localparam int BLW = 2;
    localparam int BAW = PW + BGW;

`ifdef KMUL_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [63:0] P = 64'hFFFF_FFFE_0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          a_in_valid, a_in_ready, a_in_last;
    logic [PW-1:0] a_in_prod;
    logic          a_out_valid, a_out_ready, a_out_ovf;
    logic [AW-1:0] a_out_acc;
    logic [LW-1:0] a_out_count;

    logic           b_in_valid, b_in_ready, b_in_last;
    logic [PW-1:0]  b_in_prod;
    logic           b_out_valid, b_out_ready, b_out_ovf;
    logic [BAW-1:0] b_out_acc;
    logic [BLW-1:0] b_out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kmul_dot_acc #(.PW(PW), .GW(GW), .LEN_W(LW)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_prod(a_in_prod), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_acc(a_out_acc), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    kmul_dot_acc #(.PW(PW), .GW(BGW), .LEN_W(BLW)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_prod(b_in_prod), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_acc(b_out_acc), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    // Reference: exact integer sum, then clamp or wrap to the accumulator width.
    function automatic void model(input logic [63:0] q[$], input int aw, input int lw,
                                  output logic [127:0] e_acc, output int e_cnt,
                                  output bit e_ovf);
        logic [127:0] total;
        logic [127:0] lim;
        int cmax;
        total = '0;
        lim = (128'd1 << aw) - 128'd1;
        foreach (q[j]) total = total + {64'd0, q[j]};
        e_ovf = total > lim;
        if (SAT) e_acc = e_ovf ? lim : total;
        else e_acc = total & lim;
        cmax = (1 << lw) - 1;
        e_cnt = (q.size() > cmax) ? cmax : q.size();
    endfunction

    task automatic a_send(input logic [63:0] q[$], input bit close, input int gap);
        int i = 0;
        int n = 0;
        while (i < q.size() && n < 300) begin
            if ($urandom_range(99) < gap) begin
                a_in_valid = 1'b0;
                a_in_prod  = {$urandom, $urandom};
                a_in_last  = 1'($urandom_range(1));
            end else begin
                a_in_valid = 1'b1;
                a_in_prod  = q[i];
                a_in_last  = close && (i == q.size() - 1);
            end
            if (a_in_valid && a_in_ready) i++;
            n++;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        checks++;
        if (i != q.size()) begin
            errors++;
            $display("FAIL a_send_timeout beats got %0d exp %0d", i, q.size());
        end
    endtask

    task automatic b_send(input logic [63:0] q[$]);
        int i = 0;
        int n = 0;
        while (i < q.size() && n < 100) begin
            b_in_valid = 1'b1;
            b_in_prod  = q[i];
            b_in_last  = (i == q.size() - 1);
            if (b_in_ready) i++;
            n++;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        checks++;
        if (i != q.size()) begin
            errors++;
            $display("FAIL b_send_timeout beats got %0d exp %0d", i, q.size());
        end
    endtask

    task automatic a_pop;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({a_out_valid, a_in_ready, a_out_ovf} !== 3'b010 || a_out_acc !== '0 ||
            a_out_count !== '0) begin
            errors++;
            $display("FAIL reset_state got v%b r%b o%b acc %h cnt %0d exp v0 r1 o0 acc 0 cnt 0",
                     a_out_valid, a_in_ready, a_out_ovf, a_out_acc, a_out_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_group;
        logic [63:0] q[$];
        q = {64'd10, 64'd20};
        a_send(q, 1'b0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_acc got v%b r%b cnt %0d exp v0 r1 cnt 0",
                     a_out_valid, a_in_ready, a_out_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        q = {64'd9};
        a_send(q, 1'b1, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_acc !== '0) begin
            errors++;
            $display("FAIL reset_in_hold got v%b r%b acc %h exp v0 r1 acc 0",
                     a_out_valid, a_in_ready, a_out_acc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        q = {64'd5};
        a_send(q, 1'b1, 0);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_acc !== AW'(5) || a_out_count !== LW'(1)) begin
            errors++;
            $display("FAIL after_reset_group got v%b acc %h cnt %0d exp v1 acc 5 cnt 1",
                     a_out_valid, a_out_acc, a_out_count);
        end
        a_pop();
    endtask

    task automatic test_single;
        logic [63:0] q[$];
        q = {P};
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_valid got %b exp 0", a_out_valid);
        end
        a_send(q, 1'b1, 0);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_acc !== {16'd0, P} || a_out_count !== LW'(1) ||
            a_out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_beat got v%b acc %h cnt %0d ovf %b exp v1 acc %h cnt 1 ovf 0",
                     a_out_valid, a_out_acc, a_out_count, a_out_ovf, P);
        end
        a_pop();
    endtask

    task automatic test_stall;
        logic [63:0] q[$];
        logic [AW-1:0] exp_acc;
        q = {P, P};
        exp_acc = AW'(80'h1_FFFF_FFFC_0000_0002);
        a_send(q, 1'b1, 0);
        for (int s = 0; s < 4; s++) begin
            // Offered beats during HOLD must be refused and leave the result intact.
            a_in_valid = 1'b1;
            a_in_prod  = 64'hDEAD;
            a_in_last  = 1'b1;
            a_out_ready = (s == 3);
            checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_acc !== exp_acc ||
                a_out_count !== LW'(2) || a_out_ovf !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d got v%b r%b acc %h cnt %0d ovf %b exp v1 r0 acc %h cnt 2 ovf 0",
                         s, a_out_valid, a_in_ready, a_out_acc, a_out_count, a_out_ovf, exp_acc);
            end
            @(posedge clk); #1;
        end
        a_in_valid  = 1'b0;
        a_in_last   = 1'b0;
        a_out_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got v%b r%b exp v0 r1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] items [4];
        bit lasts [4];
        int acc_cyc [4];
        logic [AW-1:0] r_acc[$];
        int r_cnt[$];
        int i = 0;
        items = '{64'd1, 64'd2, 64'd3, 64'd7};
        lasts = '{1'b0, 1'b0, 1'b1, 1'b1};
        acc_cyc = '{-1, -1, -1, -1};
        a_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (a_out_valid) begin
                r_acc.push_back(a_out_acc);
                r_cnt.push_back(int'(a_out_count));
            end
            a_in_valid = (i < 4);
            a_in_prod  = (i < 4) ? items[i] : 64'd0;
            a_in_last  = (i < 4) ? lasts[i] : 1'b0;
            if (a_in_valid && a_in_ready) begin
                acc_cyc[i] = c;
                i++;
            end
            @(posedge clk); #1;
        end
        a_in_valid  = 1'b0;
        a_in_last   = 1'b0;
        a_out_ready = 1'b0;
        checks++;
        if (r_acc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count results got %0d exp 2", r_acc.size());
        end else begin
            checks++;
            if (r_acc[0] !== AW'(6) || r_cnt[0] != 3 || r_acc[1] !== AW'(7) || r_cnt[1] != 1) begin
                errors++;
                $display("FAIL b2b_results got %0d/%0d %0d/%0d exp 6/3 7/1",
                         r_acc[0], r_cnt[0], r_acc[1], r_cnt[1]);
            end
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] != 1 || acc_cyc[2] - acc_cyc[1] != 1 ||
            acc_cyc[3] - acc_cyc[2] != 2) begin
            errors++;
            $display("FAIL b2b_timing accept cycles got %0d %0d %0d %0d exp consecutive then one bubble",
                     acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3]);
        end
    endtask

    task automatic test_random;
        logic [63:0] q[$];
        logic [127:0] e_acc;
        int e_cnt;
        bit e_ovf;
        int len;
        int stall;
        for (int g = 0; g < 30; g++) begin
            q.delete();
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) q.push_back({$urandom, $urandom});
            model(q, AW, LW, e_acc, e_cnt, e_ovf);
            a_out_ready = 1'($urandom_range(1));
            a_send(q, 1'b1, 30);
            a_out_ready = 1'b0;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
            end
            checks++;
            if (a_out_valid !== 1'b1 || a_out_acc !== e_acc[AW-1:0] ||
                int'(a_out_count) != e_cnt || a_out_ovf !== e_ovf) begin
                errors++;
                $display("FAIL random_group_%0d got v%b acc %h cnt %0d ovf %b exp v1 acc %h cnt %0d ovf %b",
                         g, a_out_valid, a_out_acc, a_out_count, a_out_ovf,
                         e_acc[AW-1:0], e_cnt, e_ovf);
            end
            a_pop();
        end
    endtask

    task automatic test_overflow;
        logic [63:0] q[$];
        logic [127:0] e_acc;
        int e_cnt;
        bit e_ovf;
        for (int n = 2; n <= 3; n++) begin
            q.delete();
            for (int j = 0; j < n; j++) q.push_back(P);
            model(q, BAW, BLW, e_acc, e_cnt, e_ovf);
            b_send(q);
            checks++;
            if (b_out_valid !== 1'b1 || b_out_acc !== e_acc[BAW-1:0] ||
                int'(b_out_count) != e_cnt || b_out_ovf !== e_ovf) begin
                errors++;
                $display("FAIL overflow_%0d_beats got v%b acc %h cnt %0d ovf %b exp v1 acc %h cnt %0d ovf %b",
                         n, b_out_valid, b_out_acc, b_out_count, b_out_ovf,
                         e_acc[BAW-1:0], e_cnt, e_ovf);
            end
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
    endtask

    task automatic test_count_sat;
        logic [63:0] q[$];
        q = {64'd1, 64'd1, 64'd1, 64'd1, 64'd1};
        b_send(q);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_count !== 2'd3 || b_out_acc !== BAW'(5) ||
            b_out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL count_sat got v%b cnt %0d acc %h ovf %b exp v1 cnt 3 acc 5 ovf 0",
                     b_out_valid, b_out_count, b_out_acc, b_out_ovf);
        end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_last = 1'b0; a_in_prod = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_in_prod = '0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_reset_mid_group();
        test_single();
        test_stall();
        test_back_to_back();
        test_random();
        test_overflow();
        test_count_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
